// File: rtl/alu_operand_sequencer_if.sv
// rtl/alu_operand_sequencer_if.sv - beat input, ALU drive/return and result output bundle
interface alu_operand_sequencer_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic [3:0] alu_sel;
  logic [6:0] alu_result;
  logic       alu_carry;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_result;
  logic       out_carry;

  modport master (
    output in_valid, in_data, alu_result, alu_carry, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_carry
  );

  modport slave (
    input  in_valid, in_data, alu_result, alu_carry, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_result, out_carry
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - two-beat operand loader, settle timer and result holder for the 2-bit ALU
module alu_operand_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int COUNT_W       = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  alu_operand_sequencer_if.slave bus,
  output logic [COUNT_W-1:0]   op_count,
  output logic                 busy
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    LOAD_AB  = 2'd0,
    LOAD_SEL = 2'd1,
    SETTLE   = 2'd2,
    RESULT   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] settle_cnt;
  logic             ab_fire;
  logic             sel_fire;
  logic             capture;
  logic             out_fire;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= LOAD_AB;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD_AB:  if (ab_fire)  state_next = LOAD_SEL;
      LOAD_SEL: if (sel_fire) state_next = SETTLE;
      SETTLE:   if (capture)  state_next = RESULT;
      RESULT:   if (out_fire) state_next = LOAD_AB;
      default:  state_next = LOAD_AB;
    endcase
  end

  // in_ready is gated by reset_n directly so upstream never sees a ready beat during reset
  always_comb begin
    bus.in_ready = reset_n && ((state == LOAD_AB) || (state == LOAD_SEL));
    busy         = (state != LOAD_AB);
    ab_fire      = (state == LOAD_AB)  && bus.in_valid && bus.in_ready;
    sel_fire     = (state == LOAD_SEL) && bus.in_valid && bus.in_ready;
    capture      = (state == SETTLE)   && (settle_cnt == '0);
    out_fire     = (state == RESULT)   && bus.out_ready;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_sel    <= '0;
      bus.out_result <= '0;
      bus.out_carry  <= 1'b0;
      bus.out_valid  <= 1'b0;
      op_count       <= '0;
      settle_cnt     <= '0;
    end else begin
      if (ab_fire) begin
        bus.alu_a <= bus.in_data[3:2];
        bus.alu_b <= bus.in_data[1:0];
      end
      if (sel_fire) begin
        bus.alu_sel <= bus.in_data;
        settle_cnt  <= SETTLE_LOAD;
      end else if ((state == SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - CNT_W'(1);
      end
      if (capture) begin
        bus.out_result <= bus.alu_result;
        bus.out_carry  <= bus.alu_carry;
        bus.out_valid  <= 1'b1;
      end else if (out_fire) begin
        bus.out_valid <= 1'b0;
      end
      if (out_fire) begin
        op_count <= op_count + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - directed bench for alu_operand_sequencer (default and SETTLE_CYCLES=4 builds)
module tb_alu_operand_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] op_count1;
  logic [7:0] op_count4;
  logic       busy1;
  logic       busy4;
  int         tests = 0;
  int         fails = 0;

  always #5 clock = ~clock;

  alu_operand_sequencer_if bus1 ();
  alu_operand_sequencer_if bus4 ();

  alu_operand_sequencer dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus1.slave),
    .op_count (op_count1),
    .busy     (busy1)
  );

  alu_operand_sequencer #(.SETTLE_CYCLES(4), .COUNT_W(8)) dut4 (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus4.slave),
    .op_count (op_count4),
    .busy     (busy4)
  );

  // Stand-in for the 2-bit ALU: only the opcodes used below, returns {carry, result}
  function automatic logic [7:0] alu_model(input logic [1:0] a, input logic [1:0] b, input logic [3:0] sel);
    logic [6:0] r;
    logic       c;
    r = '0;
    c = 1'b0;
    case (sel)
      4'b0010: begin r = 7'(a * b); c = (a * b) > 3; end
      4'b1000: r = {5'b0, a & b};
      4'b1001: r = {5'b0, a | b};
      4'b1110: begin r = {6'b0, a > b};  c = a > b;  end
      4'b1111: begin r = {6'b0, a == b}; c = a == b; end
      default: r = '0;
    endcase
    return {c, r};
  endfunction

  always_comb begin
    {bus1.alu_carry, bus1.alu_result} = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_sel);
    {bus4.alu_carry, bus4.alu_result} = alu_model(bus4.alu_a, bus4.alu_b, bus4.alu_sel);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic run_op1(input logic [3:0] ab, input logic [3:0] sel);
    bus1.in_valid = 1'b1;
    bus1.in_data  = ab;
    bus1.out_ready = 1'b1;
    cyc(1);
    bus1.in_data = sel;
    cyc(1);
    bus1.in_valid = 1'b0;
    cyc(2);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.out_ready = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_data   = '0;
    bus4.out_ready = 1'b0;
    cyc(2);

    chk("rst_in_ready", bus1.in_ready, 0);
    chk("rst_out_valid", bus1.out_valid, 0);
    chk("rst_alu_a", bus1.alu_a, 0);
    chk("rst_op_count", op_count1, 0);
    chk("rst_busy", busy1, 0);
    reset_n = 1'b1;
    cyc(1);
    chk("idle_in_ready", bus1.in_ready, 1);

    // A=3 B=2, multiply, in_valid held throughout
    bus1.in_valid  = 1'b1;
    bus1.in_data   = 4'b1110;
    bus1.out_ready = 1'b1;
    cyc(1);
    chk("t1_alu_a", bus1.alu_a, 3);
    chk("t1_alu_b", bus1.alu_b, 2);
    chk("t1_busy", busy1, 1);
    chk("t1_in_ready_sel", bus1.in_ready, 1);
    bus1.in_data = 4'b0010;
    cyc(1);
    chk("t1_alu_sel", bus1.alu_sel, 4'b0010);
    chk("t1_settle_in_ready", bus1.in_ready, 0);
    chk("t1_settle_out_valid", bus1.out_valid, 0);
    cyc(1);
    chk("t1_out_valid", bus1.out_valid, 1);
    chk("t1_out_result", bus1.out_result, 6);
    chk("t1_out_carry", bus1.out_carry, 1);
    cyc(1);
    bus1.in_valid = 1'b0;
    chk("t1_op_count", op_count1, 1);
    chk("t1_out_valid_clr", bus1.out_valid, 0);
    chk("t1_in_ready_back", bus1.in_ready, 1);

    // A=3 B=2, AND, result stalled five cycles with stray in_valid pulses
    bus1.out_ready = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.in_data   = 4'b1110;
    cyc(1);
    bus1.in_data = 4'b1000;
    cyc(1);
    bus1.in_data = 4'b0101;
    cyc(1);
    chk("t2_out_valid", bus1.out_valid, 1);
    chk("t2_out_result", bus1.out_result, 2);
    chk("t2_out_carry", bus1.out_carry, 0);
    for (int i = 0; i < 5; i++) begin
      bus1.in_valid = ~bus1.in_valid;
      cyc(1);
      chk("t2_stall_valid", bus1.out_valid, 1);
      chk("t2_stall_result", bus1.out_result, 2);
      chk("t2_stall_in_ready", bus1.in_ready, 0);
      chk("t2_stall_busy", busy1, 1);
      chk("t2_stall_count", op_count1, 1);
      chk("t2_stall_alu_a", bus1.alu_a, 3);
    end
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b1;
    cyc(1);
    chk("t2_op_count", op_count1, 2);
    chk("t2_out_valid_clr", bus1.out_valid, 0);
    cyc(2);
    chk("t2_idle_alu_a", bus1.alu_a, 3);
    chk("t2_idle_alu_sel", bus1.alu_sel, 4'b1000);

    // back to back: A=2 B=2 equal, then A=1 B=2 greater-than
    bus1.in_valid = 1'b1;
    bus1.in_data  = 4'b1010;
    cyc(1);
    bus1.in_data = 4'b1111;
    cyc(1);
    bus1.in_data = 4'b0110;
    cyc(1);
    chk("t3a_out_result", bus1.out_result, 1);
    chk("t3a_out_carry", bus1.out_carry, 1);
    chk("t3a_in_ready", bus1.in_ready, 0);
    cyc(1);
    chk("t3a_in_ready_back", bus1.in_ready, 1);
    chk("t3a_op_count", op_count1, 3);
    chk("t3a_alu_a_hold", bus1.alu_a, 2);
    cyc(1);
    chk("t3b_alu_a", bus1.alu_a, 1);
    chk("t3b_alu_b", bus1.alu_b, 2);
    bus1.in_data = 4'b1110;
    cyc(1);
    bus1.in_valid = 1'b0;
    cyc(1);
    chk("t3b_out_result", bus1.out_result, 0);
    chk("t3b_out_carry", bus1.out_carry, 0);
    chk("t3b_out_valid", bus1.out_valid, 1);
    cyc(1);
    chk("t3b_in_ready_back", bus1.in_ready, 1);
    chk("t3b_op_count", op_count1, 4);

    // SETTLE_CYCLES=4 build: gap between beats, then OR
    bus4.in_valid = 1'b1;
    bus4.in_data  = 4'b0110;
    cyc(1);
    bus4.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t4_gap_in_ready", bus4.in_ready, 1);
      chk("t4_gap_busy", busy4, 1);
    end
    bus4.in_valid = 1'b1;
    bus4.in_data  = 4'b1001;
    cyc(1);
    bus4.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("t4_settle_out_valid", bus4.out_valid, 0);
      cyc(1);
    end
    chk("t4_early_out_valid", bus4.out_valid, 0);
    cyc(1);
    chk("t4_out_valid", bus4.out_valid, 1);
    chk("t4_out_result", bus4.out_result, 3);
    bus4.out_ready = 1'b1;
    cyc(1);
    chk("t4_op_count", op_count4, 1);
    bus4.out_ready = 1'b0;

    // reset while in SETTLE
    bus1.in_valid = 1'b1;
    bus1.in_data  = 4'b1110;
    cyc(1);
    bus1.in_data = 4'b0010;
    cyc(1);
    bus1.in_valid = 1'b0;
    chk("t5_in_settle_busy", busy1, 1);
    reset_n = 1'b0;
    cyc(1);
    chk("t5_out_valid", bus1.out_valid, 0);
    chk("t5_out_result", bus1.out_result, 0);
    chk("t5_alu_sel", bus1.alu_sel, 0);
    chk("t5_alu_a", bus1.alu_a, 0);
    chk("t5_op_count", op_count1, 0);
    chk("t5_in_ready", bus1.in_ready, 0);
    chk("t5_busy", busy1, 0);
    chk("t5_dut4_op_count", op_count4, 0);
    reset_n = 1'b1;
    cyc(1);
    run_op1(4'b0110, 4'b1001);
    chk("t5_after_count", op_count1, 1);
    chk("t5_after_result", bus1.out_result, 3);

    // counter wrap
    for (int i = 0; i < 254; i++) run_op1(4'b1111, 4'b1000);
    chk("t6_count_255", op_count1, 255);
    run_op1(4'b1111, 4'b1000);
    chk("t6_count_wrap", op_count1, 0);
    chk("t6_out_result", bus1.out_result, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
